serial_alu_sequencer: RTL and testbench
=======================================

// Module: serial_alu_sequencer
// PURPOSE
//  Bit-serial ALU controller. Drives an external one-bit ALU slice, LSB first, over WIDTH cycles.
//  Holds the operand shift registers and the carry flip-flop between bits, and assembles the result.
//  It is the initiator for the slice's a/b/CarryIn/Binvert/Operation interface.
//  Sits between register-file read ports and write-back, in place of a WIDTH-slice ripple ALU.
// PARAMETERS
//  WIDTH   32   operand/result width in bits (>=2)
// PORTS
//  clock          in   1      rising-edge clock
//  reset_n        in   1      asynchronous active-low reset
//  start          in   1      request; sampled only in IDLE
//  a              in   WIDTH  operand A, captured when start is accepted
//  b              in   WIDTH  operand B, captured when start is accepted
//  Binvert        in   1      invert B (with op 10 = subtract), captured at start
//  Operation      in   2      00 AND, 01 OR, 10 ADD/SUB, 11 SLT (macro), captured at start
//  busy           out  1      high in RUN
//  done           out  1      one-cycle pulse; result fields valid
//  result         out  WIDTH  result; held until the next accepted start
//  carry_out      out  1      final carry (ADD/SUB only, else 0)
//  overflow       out  1      signed overflow (ADD/SUB only, else 0)
//  zero           out  1      result == 0
//  slice_a        out  1      to slice a
//  slice_b        out  1      to slice b
//  slice_cin      out  1      to slice CarryIn
//  slice_binvert  out  1      to slice Binvert
//  slice_op       out  2      to slice Operation
//  slice_result   in   1      from slice Result
//  slice_cout     in   1      from slice CarryOut
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - state=IDLE.
//   - All outputs, shift regs, carry FF and bit counter = 0.
//  FSM: IDLE -> RUN -> DONE -> IDLE.
//   - IDLE: start=1 at edge k captures a, b, Binvert, Operation; carry FF <= Binvert; counter <= 0; -> RUN.
//   - RUN: one bit per cycle.
//     - Slice outputs combinational from a_sh[0], b_sh[0], carry FF, captured Binvert/Operation.
//     - At each edge: result shifts right with slice_result entering the MSB; a_sh/b_sh shift right.
//     - Carry FF <= slice_cout only when op=10/11; otherwise carry FF is held.
//       The slice does not update CarryOut for AND/OR, so slice_cout is ignored then.
//     - After WIDTH edges (edge k+WIDTH) -> DONE.
//   - DONE: done=1 for exactly one cycle, then -> IDLE at edge k+WIDTH+1.
//   - Latency: result valid (done=1) in the cycle after edge k+WIDTH.
//  start in RUN or DONE is ignored (no queueing); busy=0 in IDLE and DONE.
//  Slice outputs are all 0 in IDLE and DONE.
//  carry_out = final carry FF.
//  overflow = (carry into MSB) ^ (carry out of MSB); the carry into the MSB is latched in the last RUN cycle.
//  zero = ~|result. It is registered and updated together with done.
//  Async reset mid-RUN aborts the operation: no done pulse, result=0; the next start runs normally.
// CONFIGURATION
//  SERIAL_ALU_SLT_EN defined:
//   - op 11 runs A-B: slice_op=10, slice_binvert=1, carry FF init 1.
//   - At DONE: result = {WIDTH-1 zeros, sign_bit ^ overflow}; carry_out=0; overflow=0.
//  SERIAL_ALU_SLT_EN undefined:
//   - op 11 is still accepted and takes the same latency; slice_op=00 during RUN.
//   - Result forced 0, carry_out=0, overflow=0, zero=1.
// TESTING (WIDTH=8, slice instantiated in bench)
//  1. reset_n low mid-idle -> busy, done, result, carry_out, overflow, zero all 0.
//  2. ADD 8'h7F+8'h01 (Binvert=0, op 10) -> done exactly 9 cycles after start edge; result 8'h80, carry_out 0, overflow 1, zero 0.
//  3. SUB 8'h05-8'h07 -> 8'hFE, carry_out 0, overflow 0; then SUB 8'h33-8'h33 -> 8'h00, carry_out 1, zero 1.
//  4. AND 8'hF0&8'h3C -> 8'h30, carry_out 0; OR same operands -> 8'hFC; 2nd start pulse during RUN ignored (exactly one done).
//  5. reset_n pulse at RUN bit 4 of ADD 8'hFF+8'h01 -> no done, outputs 0; following ADD 8'h02+8'h03 -> 8'h05.
//  6. op 11, a=8'h80, b=8'h01: with SERIAL_ALU_SLT_EN -> 8'h01; without -> 8'h00, zero 1.

Source files
------------

// File: rtl/serial_alu_sequencer_if.sv
// Request/result bus and one-bit ALU slice bus of the bit-serial ALU sequencer.
// The sequencer uses the slave modport; the requester together with the slice uses master.
interface serial_alu_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             Binvert;
    logic [1:0]       Operation;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;
    logic             zero;
    logic             slice_a;
    logic             slice_b;
    logic             slice_cin;
    logic             slice_binvert;
    logic [1:0]       slice_op;
    logic             slice_result;
    logic             slice_cout;

    modport slave (
        input  start, a, b, Binvert, Operation, slice_result, slice_cout,
        output busy, done, result, carry_out, overflow, zero,
               slice_a, slice_b, slice_cin, slice_binvert, slice_op
    );

    modport master (
        output start, a, b, Binvert, Operation, slice_result, slice_cout,
        input  busy, done, result, carry_out, overflow, zero,
               slice_a, slice_b, slice_cin, slice_binvert, slice_op
    );
endinterface

// File: rtl/serial_alu_sequencer.sv
// Bit-serial ALU controller: feeds an external one-bit slice LSB first over WIDTH cycles.
// Define SERIAL_ALU_SLT_EN to make op 11 a set-less-than; otherwise op 11 yields zero.
module serial_alu_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset_n,
    serial_alu_sequencer_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_q;
    logic [CW-1:0]    cnt;
    logic             carry_q;
    logic             binv_q;
    logic [1:0]       op_q;
    logic             busy_q;
    logic             done_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;

    logic             run;
    logic             last;
    logic             is_add;
    logic             is_slt;
    logic             arith;
    logic             carry_init;
    logic [1:0]       op_run;
    logic             binv_run;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] res_final;
    logic             ovf_next;

    // Final result selection; op 11 collapses the subtraction into a single less-than bit.
    function automatic logic [WIDTH-1:0] final_result(input logic [1:0] op,
                                                      input logic [WIDTH-1:0] shifted,
                                                      input logic ovf);
        final_result = shifted;
        if (op == 2'b11) begin
`ifdef SERIAL_ALU_SLT_EN
            final_result = {{(WIDTH-1){1'b0}}, shifted[WIDTH-1] ^ ovf};
`else
            final_result = '0;
`endif
        end
    endfunction

    assign run    = (state == RUN);
    assign last   = (cnt == CW'(WIDTH - 1));
    assign is_add = (op_q == 2'b10);
    assign is_slt = (op_q == 2'b11);
    assign arith  = op_q[1];

`ifdef SERIAL_ALU_SLT_EN
    assign op_run     = is_slt ? 2'b10 : op_q;
    assign binv_run   = binv_q | is_slt;
    assign carry_init = (bus.Operation == 2'b11) ? 1'b1 : bus.Binvert;
`else
    assign op_run     = is_slt ? 2'b00 : op_q;
    assign binv_run   = binv_q;
    assign carry_init = bus.Binvert;
`endif

    assign bus.slice_a       = run & a_sh[0];
    assign bus.slice_b       = run & b_sh[0];
    assign bus.slice_cin     = run & carry_q;
    assign bus.slice_binvert = run & binv_run;
    assign bus.slice_op      = run ? op_run : 2'b00;

    // The carry FF holds the carry into the bit in flight, so on the last bit it is the MSB carry-in.
    assign res_next  = {bus.slice_result, res_q[WIDTH-1:1]};
    assign ovf_next  = carry_q ^ bus.slice_cout;
    assign res_final = final_result(op_q, res_next, ovf_next);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            res_q   <= '0;
            cnt     <= '0;
            carry_q <= 1'b0;
            binv_q  <= 1'b0;
            op_q    <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_sh    <= bus.a;
                        b_sh    <= bus.b;
                        binv_q  <= bus.Binvert;
                        op_q    <= bus.Operation;
                        carry_q <= carry_init;
                        cnt     <= '0;
                        busy_q  <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    cnt  <= cnt + 1'b1;
                    if (arith) begin
                        carry_q <= bus.slice_cout;
                    end
                    if (last) begin
                        res_q  <= res_final;
                        cout_q <= is_add & bus.slice_cout;
                        ovf_q  <= is_add & ovf_next;
                        zero_q <= ~|res_final;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= DONE;
                    end else begin
                        res_q <= res_next;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.result    = res_q;
    assign bus.carry_out = cout_q;
    assign bus.overflow  = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Directed bench for serial_alu_sequencer at WIDTH=8 with a behavioural one-bit ALU slice.
// Honours SERIAL_ALU_SLT_EN for the op 11 expectation.
module tb_serial_alu_sequencer;
    localparam int W = 8;

    logic clock;
    logic reset_n;
    int   tests;
    int   fails;

    int       n_done;
    int       done_at;
    logic [7:0] res_cap;
    logic     cout_cap;
    logic     ovf_cap;
    logic     zero_cap;
    logic     sl_bb;

    serial_alu_sequencer_if #(.WIDTH(W)) bus ();

    serial_alu_sequencer #(.WIDTH(W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One-bit ALU slice: a, b^Binvert, CarryIn -> Result, CarryOut.
    assign sl_bb = bus.slice_b ^ bus.slice_binvert;
    always_comb begin
        bus.slice_result = 1'b0;
        case (bus.slice_op)
            2'b00:   bus.slice_result = bus.slice_a & sl_bb;
            2'b01:   bus.slice_result = bus.slice_a | sl_bb;
            2'b10:   bus.slice_result = bus.slice_a ^ sl_bb ^ bus.slice_cin;
            default: bus.slice_result = 1'b0;
        endcase
        bus.slice_cout = (bus.slice_a & sl_bb) | (bus.slice_a & bus.slice_cin) | (sl_bb & bus.slice_cin);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts one operation and watches 14 cycles; done_at numbers the start cycle as 0.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic binv,
                          input logic [1:0] op, input bit extra_start);
        bus.a         = ta;
        bus.b         = tb;
        bus.Binvert   = binv;
        bus.Operation = op;
        bus.start     = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        check("busy_in_run", 32'(bus.busy), 32'h1);
        n_done  = 0;
        done_at = 0;
        for (int i = 1; i <= 14; i++) begin
            bus.start = (extra_start && i == 3);
            @(posedge clock); #1;
            if (bus.done) begin
                n_done++;
                if (done_at == 0) begin
                    done_at  = i + 1;
                    res_cap  = bus.result;
                    cout_cap = bus.carry_out;
                    ovf_cap  = bus.overflow;
                    zero_cap = bus.zero;
                end
            end
        end
        bus.start = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        res_cap = '0; cout_cap = 0; ovf_cap = 0; zero_cap = 0;
        bus.start = 0; bus.a = '0; bus.b = '0; bus.Binvert = 0; bus.Operation = 2'b00;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_done", 32'(bus.done), 32'h0);
        check("rst_result", 32'(bus.result), 32'h0);
        check("rst_slice_op", 32'(bus.slice_op), 32'h0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        // ADD 7F + 01
        run_op(8'h7F, 8'h01, 1'b0, 2'b10, 1'b0);
        check("add_done_cycle", 32'(done_at), 32'd9);
        check("add_done_count", 32'(n_done), 32'd1);
        check("add_result", 32'(res_cap), 32'h80);
        check("add_carry", 32'(cout_cap), 32'h0);
        check("add_ovf", 32'(ovf_cap), 32'h1);
        check("add_zero", 32'(zero_cap), 32'h0);
        check("add_result_held", 32'(bus.result), 32'h80);
        check("idle_busy", 32'(bus.busy), 32'h0);

        // Reset while idle clears the held result and flags
        reset_n = 1'b0;
        #2;
        check("idle_rst_busy", 32'(bus.busy), 32'h0);
        check("idle_rst_done", 32'(bus.done), 32'h0);
        check("idle_rst_result", 32'(bus.result), 32'h0);
        check("idle_rst_carry", 32'(bus.carry_out), 32'h0);
        check("idle_rst_ovf", 32'(bus.overflow), 32'h0);
        check("idle_rst_zero", 32'(bus.zero), 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;

        // SUB 05 - 07
        run_op(8'h05, 8'h07, 1'b1, 2'b10, 1'b0);
        check("sub1_result", 32'(res_cap), 32'hFE);
        check("sub1_carry", 32'(cout_cap), 32'h0);
        check("sub1_ovf", 32'(ovf_cap), 32'h0);
        check("sub1_zero", 32'(zero_cap), 32'h0);

        // SUB 33 - 33
        run_op(8'h33, 8'h33, 1'b1, 2'b10, 1'b0);
        check("sub2_result", 32'(res_cap), 32'h00);
        check("sub2_carry", 32'(cout_cap), 32'h1);
        check("sub2_ovf", 32'(ovf_cap), 32'h0);
        check("sub2_zero", 32'(zero_cap), 32'h1);

        // AND F0 & 3C, with a stray start during RUN
        run_op(8'hF0, 8'h3C, 1'b0, 2'b00, 1'b1);
        check("and_result", 32'(res_cap), 32'h30);
        check("and_carry", 32'(cout_cap), 32'h0);
        check("and_done_count", 32'(n_done), 32'd1);
        check("and_done_cycle", 32'(done_at), 32'd9);

        // OR F0 | 3C
        run_op(8'hF0, 8'h3C, 1'b0, 2'b01, 1'b0);
        check("or_result", 32'(res_cap), 32'hFC);
        check("or_ovf", 32'(ovf_cap), 32'h0);

        // ADD FF + 01 aborted by reset at bit 4
        bus.a = 8'hFF; bus.b = 8'h01; bus.Binvert = 0; bus.Operation = 2'b10;
        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        repeat (4) begin
            @(posedge clock); #1;
        end
        check("abort_busy_before", 32'(bus.busy), 32'h1);
        reset_n = 1'b0;
        #2;
        check("abort_busy", 32'(bus.busy), 32'h0);
        check("abort_result", 32'(bus.result), 32'h0);
        check("abort_slice_a", 32'(bus.slice_a), 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clock); #1;
            if (bus.done) n_done++;
        end
        check("abort_no_done", 32'(n_done), 32'd0);

        run_op(8'h02, 8'h03, 1'b0, 2'b10, 1'b0);
        check("post_abort_result", 32'(res_cap), 32'h05);
        check("post_abort_done", 32'(n_done), 32'd1);

        // op 11 with a=80, b=01
        run_op(8'h80, 8'h01, 1'b0, 2'b11, 1'b0);
        check("slt_done_cycle", 32'(done_at), 32'd9);
        check("slt_carry", 32'(cout_cap), 32'h0);
        check("slt_ovf", 32'(ovf_cap), 32'h0);
`ifdef SERIAL_ALU_SLT_EN
        check("slt_result", 32'(res_cap), 32'h01);
        check("slt_zero", 32'(zero_cap), 32'h0);
`else
        check("slt_result", 32'(res_cap), 32'h00);
        check("slt_zero", 32'(zero_cap), 32'h1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
